// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, frame header and error codes for uart_frame_parse
package uart_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_LEN, S_DATA, S_CHK} state_t;
  localparam logic [7:0] HDR     = 8'hA5;
  localparam logic [1:0] ERR_CHK = 2'd1;
  localparam logic [1:0] ERR_LEN = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;
endpackage

// File: rtl/uart_edge_det.sv
// uart_edge_det: one-cycle strobe on the rising edge of i_sig
// Ports: sys_clk, sys_rst_n (sync, active-low) | i_sig level in | o_pulse high in the cycle i_sig rises
module uart_edge_det (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic i_sig,
  output logic o_pulse
);
  logic r_prev;
  always_ff @(posedge sys_clk) r_prev <= sys_rst_n ? i_sig : 1'b0;
  assign o_pulse = i_sig & ~r_prev;
endmodule

// File: rtl/uart_frame_parse.sv
// uart_frame_parse: parses A5/CMD/LEN/payload/CHK frames from a UART byte stream
// Ports: sys_clk, sys_rst_n (sync, active-low) | uart_done, uart_data byte input
//        frame_valid/frame_err one-cycle pulses | frame_cmd, frame_len, frame_payload of last good frame
//        err_code reason of last error (1 checksum, 2 length, 3 timeout)
module uart_frame_parse
  import uart_pkg::*;
#(
  parameter int CLK_FREQ      = 50000000,
  parameter int UART_BPS      = 9600,
  parameter int MAX_LEN       = 8,
  parameter int TIMEOUT_BYTES = 20
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        uart_done,
  input  logic [7:0]  uart_data,
  output logic        frame_valid,
  output logic [7:0]  frame_cmd,
  output logic [3:0]  frame_len,
  output logic [63:0] frame_payload,
  output logic        frame_err,
  output logic [1:0]  err_code
);
  localparam int TIMEOUT_CNT = (CLK_FREQ / UART_BPS) * TIMEOUT_BYTES;
  localparam int TW = ($clog2(TIMEOUT_CNT) > 20) ? $clog2(TIMEOUT_CNT) : 20;
  state_t r_state, w_next;
  logic w_stb, w_good, w_bad, w_tmo;
  logic [1:0] w_code;
  logic [7:0] r_cmd, r_sum;
  logic [3:0] r_len;
  logic [2:0] r_cnt;
  logic [63:0] r_buf;
  logic [TW-1:0] r_tcnt;
  logic r_valid, r_err;
  logic [1:0] r_code;
  logic [7:0] r_fcmd;
  logic [3:0] r_flen;
  logic [63:0] r_fpay;
  uart_edge_det u_edge (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .i_sig    (uart_done),
    .o_pulse  (w_stb)
  );
  // a strobe in the terminal-count cycle suppresses the timeout
  always_comb begin
    w_next = r_state;
    w_good = 1'b0;
    w_bad  = 1'b0;
    w_code = ERR_CHK;
    w_tmo  = (r_state != S_IDLE) && !w_stb && (r_tcnt == TW'(TIMEOUT_CNT - 1));
    if (w_tmo) begin
      w_next = S_IDLE;
      w_bad  = 1'b1;
      w_code = ERR_TMO;
    end else if (w_stb) begin
      case (r_state)
        S_IDLE: w_next = (uart_data == HDR) ? S_CMD : S_IDLE;
        S_CMD:  w_next = S_LEN;
        S_LEN: begin
          w_bad  = uart_data > 8'(MAX_LEN);
          w_code = ERR_LEN;
          w_next = w_bad ? S_IDLE : (uart_data == 8'd0 ? S_CHK : S_DATA);
        end
        S_DATA: w_next = ({1'b0, r_cnt} == r_len - 4'd1) ? S_CHK : S_DATA;
        S_CHK: begin
          w_good = uart_data == r_sum;
          w_bad  = !w_good;
          w_next = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge sys_clk) r_state <= sys_rst_n ? w_next : S_IDLE;
  // the running sum covers CMD and payload; the LEN byte is not added
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_cmd   <= '0;
      r_sum   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_tcnt  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= '0;
      r_fcmd  <= '0;
      r_flen  <= '0;
      r_fpay  <= '0;
    end else begin
      r_valid <= w_good;
      r_err   <= w_bad;
      if (w_bad) r_code <= w_code;
      r_tcnt <= (r_state == S_IDLE || w_stb) ? '0 : r_tcnt + 1'b1;
      if (w_stb) begin
        case (r_state)
          S_IDLE: if (uart_data == HDR) r_buf <= '0;
          S_CMD: begin
            r_cmd <= uart_data;
            r_sum <= uart_data;
          end
          S_LEN: begin
            r_len <= uart_data[3:0];
            r_cnt <= '0;
          end
          S_DATA: begin
            r_buf[{r_cnt, 3'b000} +: 8] <= uart_data;
            r_sum <= r_sum + uart_data;
            r_cnt <= r_cnt + 1'b1;
          end
          default: ;
        endcase
      end
      if (w_good) begin
        r_fcmd <= r_cmd;
        r_flen <= r_len;
        r_fpay <= r_buf;
      end
    end
  end
  assign frame_valid   = r_valid;
  assign frame_err     = r_err;
  assign err_code      = r_code;
  assign frame_cmd     = r_fcmd;
  assign frame_len     = r_flen;
  assign frame_payload = r_fpay;
endmodule
